wb_scoreboard: RTL and testbench

- Producer side of the register file's write port: owns the `load`/`dest`/`in` signals that the regfile consumes.
- Merges single-cycle pipeline results with results from a long-latency unit (mul/div). Long-latency results are buffered in a small FIFO.
- Keeps a per-register pending scoreboard and raises a combinational issue hazard for RAW/WAW conflicts.
- The hazard accounts for the regfile's same-cycle write-to-read bypass.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_fifo.sv | 75 +++++++
 rtl/wb_scoreboard.sv | 110 +++++++++++
 tb/tb_wb_scoreboard.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback scoreboard: register index and the
// long-latency completion entry that travels through the FIFO.
package wb_pkg;

    localparam int NREGS = 32;

    typedef logic [4:0] regidx_t;

    typedef struct packed {
        regidx_t     rd;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Completion FIFO for long-latency results: valid/ready push side,
// pop strobe on the read side, registered occupancy count.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    output wb_entry_t                  head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    wb_entry_t     mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign push_ready = (count_q != CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop && !empty;
    assign head       = mem_q[rd_ptr_q];
    assign count      = count_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Register-file write-port producer: arbitrates pipe vs long-latency results
// and tracks pending destinations to raise the issue hazard.
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NREGS = wb_pkg::NREGS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [4:0]             issue_rd,
    input  logic [4:0]             issue_src_a,
    input  logic [4:0]             issue_src_b,
    output logic                   hazard,
    input  logic                   pipe_valid,
    input  logic [4:0]             pipe_rd,
    input  logic [31:0]            pipe_data,
    input  logic                   lu_valid,
    output logic                   lu_ready,
    input  logic [4:0]             lu_rd,
    input  logic [31:0]            lu_data,
    output logic                   rf_load,
    output logic [4:0]             rf_dest,
    output logic [31:0]            rf_in,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   any_pending
);

    logic [NREGS-1:0] pending_q, pending_d;
    wb_entry_t        lu_entry;
    wb_entry_t        fifo_head;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             pipe_write;

    assign lu_entry   = '{rd: lu_rd, data: lu_data};
    assign pipe_write = pipe_valid && (pipe_rd != '0);

    // x0 results complete the handshake but never enter the FIFO.
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (lu_valid && (lu_rd != '0)),
        .push_ready (lu_ready),
        .push_entry (lu_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_comb begin
        rf_load  = 1'b0;
        rf_dest  = '0;
        rf_in    = '0;
        fifo_pop = 1'b0;
        if (!rst) begin
            if (pipe_write) begin
                rf_load = 1'b1;
                rf_dest = pipe_rd;
                rf_in   = pipe_data;
            end else if (!fifo_empty) begin
                rf_load  = 1'b1;
                rf_dest  = fifo_head.rd;
                rf_in    = fifo_head.data;
                fifo_pop = 1'b1;
            end
        end
    end

    // A register being written this cycle is forwarded by the regfile, so it is not a conflict.
    function automatic logic conflict(input regidx_t r);
        return (r != '0) && pending_q[r] && !(rf_load && (rf_dest == r));
    endfunction

    assign hazard = issue_valid &&
                    (conflict(issue_src_a) || conflict(issue_src_b) || conflict(issue_rd));

    always_comb begin
        pending_d = pending_q;
        if (rf_load) begin
            pending_d[rf_dest] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0) && !hazard) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign any_pending = |pending_q;

    a_hazard_no_set: assert property (@(posedge clk) disable iff (rst)
        (issue_valid && hazard && !pending_q[issue_rd]) |-> !pending_d[issue_rd]);

    a_write_pending: assert property (@(posedge clk) disable iff (rst)
        rf_load |-> pending_q[rf_dest]);

    a_no_dual_write: assert property (@(posedge clk) disable iff (rst)
        (pipe_write && !fifo_empty) |-> (pipe_rd != fifo_head.rd));

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench: a negedge monitor models the write port, FIFO and
// pending bits; directed phases add explicit checks on the notable cases.
module tb_wb_scoreboard;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd, issue_src_a, issue_src_b;
    logic        hazard;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        rf_load;
    logic [4:0]  rf_dest;
    logic [31:0] rf_in;
    logic [$clog2(DEPTH):0] fifo_count;
    logic        any_pending;

    wb_scoreboard #(.DEPTH(DEPTH), .NREGS(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_src_a (issue_src_a),
        .issue_src_b (issue_src_b),
        .hazard      (hazard),
        .pipe_valid  (pipe_valid),
        .pipe_rd     (pipe_rd),
        .pipe_data   (pipe_data),
        .lu_valid    (lu_valid),
        .lu_ready    (lu_ready),
        .lu_rd       (lu_rd),
        .lu_data     (lu_data),
        .rf_load     (rf_load),
        .rf_dest     (rf_dest),
        .rf_in       (rf_in),
        .fifo_count  (fifo_count),
        .any_pending (any_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    wb_entry_t   lu_q[$];
    logic [31:0] model_pend;
    logic        exp_load;
    logic [4:0]  exp_dest;
    logic [31:0] exp_data;
    logic        exp_pop;
    logic        exp_ready;
    logic        exp_hazard;

    function automatic logic model_conflict(input logic [4:0] r);
        return (r != 5'd0) && model_pend[r] && !(exp_load && exp_dest == r);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check("rst_rf_load", 32'(rf_load), 32'd0);
            check("rst_hazard", 32'(hazard), 32'd0);
            check("rst_lu_ready", 32'(lu_ready), 32'd1);
            check("rst_count", 32'(fifo_count), 32'd0);
            check("rst_any_pending", 32'(any_pending), 32'd0);
            lu_q.delete();
            model_pend = '0;
        end else begin
            exp_load = 1'b0;
            exp_dest = '0;
            exp_data = '0;
            exp_pop  = 1'b0;
            if (pipe_valid && pipe_rd != 5'd0) begin
                exp_load = 1'b1;
                exp_dest = pipe_rd;
                exp_data = pipe_data;
            end else if (lu_q.size() > 0) begin
                exp_load = 1'b1;
                exp_dest = lu_q[0].rd;
                exp_data = lu_q[0].data;
                exp_pop  = 1'b1;
            end
            check("mon_rf_load", 32'(rf_load), 32'(exp_load));
            if (exp_load) begin
                check("mon_rf_dest", 32'(rf_dest), 32'(exp_dest));
                check("mon_rf_in", rf_in, exp_data);
            end
            exp_ready = (lu_q.size() < DEPTH);
            check("mon_count", 32'(fifo_count), 32'(lu_q.size()));
            check("mon_lu_ready", 32'(lu_ready), 32'(exp_ready));
            check("mon_any_pending", 32'(any_pending), 32'(|model_pend));
            exp_hazard = issue_valid && (model_conflict(issue_src_a) ||
                         model_conflict(issue_src_b) || model_conflict(issue_rd));
            check("mon_hazard", 32'(hazard), 32'(exp_hazard));

            if (exp_pop) void'(lu_q.pop_front());
            if (lu_valid && exp_ready && lu_rd != 5'd0)
                lu_q.push_back('{rd: lu_rd, data: lu_data});
            if (exp_load) model_pend[exp_dest] = 1'b0;
            if (issue_valid && issue_rd != 5'd0 && !exp_hazard) model_pend[issue_rd] = 1'b1;
            model_pend[0] = 1'b0;
        end
    end

    task automatic clear_inputs();
        issue_valid = 1'b0; issue_rd = '0; issue_src_a = '0; issue_src_b = '0;
        pipe_valid  = 1'b0; pipe_rd  = '0; pipe_data = '0;
        lu_valid    = 1'b0; lu_rd    = '0; lu_data   = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_pend = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // RAW hazard and same-cycle bypass on x5
        issue(5'd5);
        @(negedge clk) check("t1_no_hazard", 32'(hazard), 32'd0);
        next_cycle();
        issue_valid = 1'b1; issue_src_a = 5'd5;
        @(negedge clk) check("t1_raw_hazard", 32'(hazard), 32'd1);
        next_cycle();
        issue_valid = 1'b1; issue_src_a = 5'd5;
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t1_bypass_hazard", 32'(hazard), 32'd0);
        check("t1_load", 32'(rf_load), 32'd1);
        check("t1_dest", 32'(rf_dest), 32'd5);
        check("t1_data", rf_in, 32'hDEAD_BEEF);
        next_cycle();
        @(negedge clk) check("t1_cleared", 32'(any_pending), 32'd0);

        // Fill FIFO while the pipe keeps the write port busy on x7
        for (int i = 1; i <= 4; i++) begin
            issue(5'(i));
            next_cycle();
        end
        issue(5'd7);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            pipe_valid = 1'b1; pipe_rd = 5'd7; pipe_data = 32'h7000 + i;
            issue(5'd7);
            lu_valid = 1'b1;
            lu_rd    = (i < 4) ? 5'(i + 1) : 5'd1;
            lu_data  = 32'hA000 + i + 1;
            if (i == 4) begin
                @(negedge clk);
                check("fill_full_ready", 32'(lu_ready), 32'd0);
                check("fill_full_count", 32'(fifo_count), 32'd4);
                check("fill_pipe_wins", 32'(rf_dest), 32'd7);
            end
            next_cycle();
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("drain_load", 32'(rf_load), 32'd1);
            check("drain_order", 32'(rf_dest), 32'(i));
            next_cycle();
        end
        @(negedge clk);
        check("drain_empty", 32'(fifo_count), 32'd0);
        check("drain_set_wins", 32'(any_pending), 32'd1);

        // Retire x7, then x0 on every path
        pipe_valid = 1'b1; pipe_rd = 5'd7; pipe_data = 32'h7777_0007;
        next_cycle();
        issue(5'd0);
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h1234_5678;
        pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hBAD0_0000;
        @(negedge clk);
        check("x0_no_load", 32'(rf_load), 32'd0);
        check("x0_lu_ready", 32'(lu_ready), 32'd1);
        next_cycle();
        @(negedge clk);
        check("x0_no_enqueue", 32'(fifo_count), 32'd0);
        check("x0_no_pending", 32'(any_pending), 32'd0);

        // Reset in the middle of a drain
        foreach (model_pend[i]) if (i == 7 || (i >= 8 && i <= 10)) begin
            issue(5'(i));
            next_cycle();
        end
        for (int i = 8; i <= 10; i++) begin
            pipe_valid = 1'b1; pipe_rd = 5'd7; pipe_data = 32'h7100 + i;
            issue(5'd7);
            lu_valid = 1'b1; lu_rd = 5'(i); lu_data = 32'hC000 + i;
            next_cycle();
        end
        check("mid_count_before_rst", 32'(fifo_count), 32'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_pending", 32'(any_pending), 32'd0);
        check("mid_rst_load", 32'(rf_load), 32'd0);
        check("mid_rst_ready", 32'(lu_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk) check("post_rst_no_write", 32'(rf_load), 32'd0);
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
